// File: rtl/fault_campaign_ctrl.sv
// Fault-campaign sequencer: captures a golden ciphertext, then sweeps fault bits and emits DFA-classified diff records.
// Latency: each bit is sampled SETTLE_CYCLES cycles after fault_bit changes; the record is valid the cycle after sampling.
// Backpressure: a record and the fault setting are held while res_ready=0; sweeping resumes on handshake. Optional: DFA_FILTER_EN.
module fault_campaign_ctrl #(
    parameter int SETTLE_CYCLES = 20,
    parameter int NUM_BITS      = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         fault_en,
    output logic [6:0]   fault_bit,
    input  logic [127:0] ciphertext,
    output logic [127:0] golden,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [6:0]   res_bit,
    output logic [127:0] res_diff,
    output logic [4:0]   res_nbytes,
    output logic         res_pattern_ok,
    output logic [7:0]   res_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GOLD_WAIT  = 3'd1,
        FAULT_WAIT = 3'd2,
        EMIT       = 3'd3,
        DONE       = 3'd4
    } state_t;

    // Byte masks (bit k = byte k) of a single faulted column after round 9.
    localparam logic [15:0] COL0_MASK = 16'h2481;
    localparam logic [15:0] COL1_MASK = 16'h4812;
    localparam logic [15:0] COL2_MASK = 16'h8124;
    localparam logic [15:0] COL3_MASK = 16'h1248;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic          settle_last;
    logic          last_bit;
    logic          keep;
    logic [127:0]  cur_diff;
    logic [15:0]   nz;
    logic [4:0]    cur_nbytes;
    logic          cur_pat;

    assign settle_last = (cnt == 8'(SETTLE_CYCLES - 1));
    assign last_bit    = (fault_bit == 7'(NUM_BITS - 1));

    assign busy      = (state == GOLD_WAIT) || (state == FAULT_WAIT) || (state == EMIT);
    assign done      = (state == DONE);
    assign res_valid = (state == EMIT);

    // Classify the live difference so it can be registered on the sample cycle.
    always_comb begin
        cur_diff = ciphertext ^ golden;
        nz       = '0;
        for (int k = 0; k < 16; k++) begin
            nz[k] = |cur_diff[127 - 8*k -: 8];
        end
        cur_nbytes = 5'($countones(nz));
        cur_pat    = (nz == COL0_MASK) || (nz == COL1_MASK) ||
                     (nz == COL2_MASK) || (nz == COL3_MASK);
`ifdef DFA_FILTER_EN
        keep = cur_pat;
`else
        keep = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = GOLD_WAIT;
            GOLD_WAIT:  if (settle_last) state_nxt = FAULT_WAIT;
            FAULT_WAIT: begin
                if (settle_last) begin
                    if (keep)          state_nxt = EMIT;
                    else if (last_bit) state_nxt = DONE;
                    else               state_nxt = FAULT_WAIT;
                end
            end
            EMIT: begin
                if (res_ready) state_nxt = last_bit ? DONE : FAULT_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle counter, fault drive, golden capture and result record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            fault_en       <= 1'b0;
            fault_bit      <= '0;
            golden         <= '0;
            res_bit        <= '0;
            res_diff       <= '0;
            res_nbytes     <= '0;
            res_pattern_ok <= 1'b0;
            res_count      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fault_en  <= 1'b0;
                        cnt       <= '0;
                        res_count <= '0;
                    end
                end
                GOLD_WAIT: begin
                    if (settle_last) begin
                        golden    <= ciphertext;
                        fault_bit <= '0;
                        fault_en  <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FAULT_WAIT: begin
                    if (settle_last) begin
                        res_diff       <= cur_diff;
                        res_bit        <= fault_bit;
                        res_nbytes     <= cur_nbytes;
                        res_pattern_ok <= cur_pat;
                        cnt            <= '0;
                        // A filtered-out record skips straight to the next bit.
                        if (!keep) begin
                            if (last_bit) fault_en  <= 1'b0;
                            else          fault_bit <= fault_bit + 7'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        if (res_count != 8'hFF) res_count <= res_count + 8'd1;
                        if (last_bit) begin
                            fault_en <= 1'b0;
                        end else begin
                            fault_bit <= fault_bit + 7'd1;
                            cnt       <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
